// File: rtl/bp_pkg.sv
// Shared branch-predictor types: PC-source encoding, indexing mode and
// the 2-bit counter state names used by the fetch and hazard units.
package bp_pkg;

  localparam logic [1:0] PCSRC_BRANCH = 2'b01;

  typedef enum logic {
    BP_BIMODAL = 1'b0,
    BP_GSHARE  = 1'b1
  } bp_mode_e;

  typedef enum logic [1:0] {
    STRONGLY_NOT_TAKEN = 2'b00,
    WEAKLY_NOT_TAKEN   = 2'b01,
    WEAKLY_TAKEN       = 2'b10,
    STRONGLY_TAKEN     = 2'b11
  } state_t;

  function automatic bp_mode_e mode_from_int(input int unsigned m);
    if (m == 32'd1) begin
      return BP_GSHARE;
    end else begin
      return BP_BIMODAL;
    end
  endfunction

endpackage

// File: rtl/bp_pht.sv
// Pattern history table: 2^IDX_W saturating counters, one combinational
// read port (MSB only) and one saturating increment/decrement write port.
module bp_pht
  import bp_pkg::*;
#(
  parameter int unsigned IDX_W     = 6,
  parameter int unsigned CTR_W     = 2,
  parameter int unsigned RESET_CTR = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [IDX_W-1:0] rd_idx_i,
  output logic             rd_taken_o,
  input  logic             wr_en_i,
  input  logic [IDX_W-1:0] wr_idx_i,
  input  logic             wr_taken_i
);

  localparam int unsigned    DEPTH   = 1 << IDX_W;
  localparam logic [CTR_W-1:0] CTR_MAX = '1;
  localparam logic [CTR_W-1:0] CTR_MIN = '0;
  localparam logic [CTR_W-1:0] CTR_RST = CTR_W'(RESET_CTR);

  logic [CTR_W-1:0] pht_q [DEPTH];
  logic [CTR_W-1:0] wr_cur_s;
  logic [CTR_W-1:0] wr_ctr_d;

  // No bypass: a same-cycle write is visible on the read port only after the edge.
  assign rd_taken_o = pht_q[rd_idx_i][CTR_W-1];
  assign wr_cur_s   = pht_q[wr_idx_i];

  // Saturating next value for the entry being trained.
  always_comb begin
    wr_ctr_d = wr_cur_s;
    if (wr_taken_i) begin
      if (wr_cur_s != CTR_MAX) begin
        wr_ctr_d = wr_cur_s + CTR_W'(1'b1);
      end else begin
        wr_ctr_d = wr_cur_s;
      end
    end else begin
      if (wr_cur_s != CTR_MIN) begin
        wr_ctr_d = wr_cur_s - CTR_W'(1'b1);
      end else begin
        wr_ctr_d = wr_cur_s;
      end
    end
  end

  // Counter array with asynchronous reset of every entry.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        pht_q[i] <= CTR_RST;
      end
    end else if (wr_en_i) begin
      pht_q[wr_idx_i] <= wr_ctr_d;
    end
  end

endmodule

// File: rtl/branch_predictor_pht.sv
// Branch predictor top: bimodal/gshare index hashing, non-speculative global
// history, mispredict detection and saturating statistics around bp_pht.
module branch_predictor_pht
  import bp_pkg::*;
#(
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned IDX_W     = 6,
  parameter int unsigned CTR_W     = 2,
  parameter int unsigned GHR_W     = 4,
  parameter int unsigned MODE      = 0,
  parameter int unsigned RESET_CTR = 0,
  parameter int unsigned STAT_W    = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] PCF,
  output logic              pred_taken_f,
  output logic [IDX_W-1:0]  pred_idx_f,
  input  logic [1:0]        PCsrcE,
  input  logic              BranchCondE,
  input  logic              pred_taken_e,
  input  logic [IDX_W-1:0]  pred_idx_e,
  output logic              mispredict_e,
  output logic [STAT_W-1:0] stat_branches,
  output logic [STAT_W-1:0] stat_mispredicts
);

  localparam bp_mode_e MODE_E = mode_from_int(MODE);

  if (GHR_W > IDX_W || GHR_W < 1 || CTR_W < 1) begin : g_param_err
    $error("branch_predictor_pht: GHR_W must be 1..IDX_W and CTR_W >= 1");
  end

  logic              upd_s;
  logic [IDX_W-1:0]  base_idx_s;
  logic [GHR_W-1:0]  ghr_q, ghr_d;
  logic [STAT_W-1:0] branches_q, branches_d;
  logic [STAT_W-1:0] mispredicts_q, mispredicts_d;
  logic              unused_pc_s;

  assign upd_s        = (PCsrcE == PCSRC_BRANCH);
  assign base_idx_s   = PCF[IDX_W+1:2];
  assign unused_pc_s  = ^{PCF[ADDR_W-1:IDX_W+2], PCF[1:0]};
  assign mispredict_e = upd_s & (pred_taken_e != BranchCondE);

  // Fetch index: PC word index, optionally folded with global history.
  always_comb begin
    pred_idx_f = base_idx_s;
    if (MODE_E == BP_GSHARE) begin
      pred_idx_f = base_idx_s ^ IDX_W'(ghr_q);
    end else begin
      pred_idx_f = base_idx_s;
    end
  end

  // History shifts in the resolved outcome; bimodal keeps it at zero.
  always_comb begin
    ghr_d = ghr_q;
    if (upd_s && (MODE_E == BP_GSHARE)) begin
      ghr_d = GHR_W'({ghr_q, BranchCondE});
    end else begin
      ghr_d = ghr_q;
    end
  end

  // Statistics stick at all-ones instead of wrapping.
  always_comb begin
    branches_d    = branches_q;
    mispredicts_d = mispredicts_q;
    if (upd_s && (branches_q != {STAT_W{1'b1}})) begin
      branches_d = branches_q + STAT_W'(1'b1);
    end else begin
      branches_d = branches_q;
    end
    if (mispredict_e && (mispredicts_q != {STAT_W{1'b1}})) begin
      mispredicts_d = mispredicts_q + STAT_W'(1'b1);
    end else begin
      mispredicts_d = mispredicts_q;
    end
  end

  // History and statistics registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ghr_q         <= '0;
      branches_q    <= '0;
      mispredicts_q <= '0;
    end else begin
      ghr_q         <= ghr_d;
      branches_q    <= branches_d;
      mispredicts_q <= mispredicts_d;
    end
  end

  assign stat_branches    = branches_q;
  assign stat_mispredicts = mispredicts_q;

  bp_pht #(
    .IDX_W     (IDX_W),
    .CTR_W     (CTR_W),
    .RESET_CTR (RESET_CTR)
  ) u_pht (
    .clk        (clk),
    .reset      (reset),
    .rd_idx_i   (pred_idx_f),
    .rd_taken_o (pred_taken_f),
    .wr_en_i    (upd_s),
    .wr_idx_i   (pred_idx_e),
    .wr_taken_i (BranchCondE)
  );

endmodule
